dual_slope_seq: RTL
===================

# dual_slope_seq

Measurement sequencer for the voltmeter's dual-slope converter. It sits in `digital_top` between the register/SPI logic and `analog_top`. It steps the analog front-end through reference-wait, auto-zero, fixed-time integrate, reference de-integrate and integrator discharge. It counts de-integrate cycles to the comparator zero-crossing and reports count, polarity, overrange and error flags.

## Interface
- `T_REF`, 1024: maximum cycles to wait for `ref_ok_i` before error.
- `T_AZ`, 256: auto-zero phase length in cycles.
- `T_INT`, 4096: fixed integrate phase length in cycles.
- `N_MAX`, 8192: de-integrate count limit (overrange threshold).
- `T_DIS`, 64: integrator discharge length in cycles.
- `CW`, 14: result/counter width; must satisfy 2^CW > N_MAX.

- `clk_i` in 1: system clock. One clock domain; reset is asynchronous and active-low.
- `rst_n_i` in 1: asynchronous active-low reset.
- `start_i` in 1: single-cycle start request; ignored while `busy_o`=1.
- `abort_i` in 1: level; abandons the conversion in progress.
- `comp_i` in 1: comparator, 1 means Vint ≥ 0. Asynchronous; 2-flop synchronized internally.
- `sat_hi_i`, `sat_lo_i` in 1 each: integrator rail flags. Asynchronous; 2-flop synchronized.
- `ref_ok_i` in 1: reference settled. Asynchronous; 2-flop synchronized.
- `afe_sel_o` out 2: front-end input select. 00 = AZ, 01 = VIN, 10 = +VREF, 11 = −VREF.
- `ref_sign_o` out 1: de-integrate polarity. 0 = +VREF, 1 = −VREF.
- `afe_reset_o` out 1: integrator discharge.
- `busy_o` out 1: high from the cycle after an accepted start through the DONE state.
- `done_o` out 1: single-cycle completion pulse.
- `result_o` out CW: de-integrate count; held until the next `done_o`.
- `polarity_o` out 1: 1 means the input was positive.
- `overrange_o` out 1: overrange flag; held until the next `done_o`.
- `err_o` out 1: error flag (reference timeout or abort); held until the next `done_o`.

## Operation
- **States:** IDLE, WAIT_REF, AUTOZERO, INTEGRATE, DEINT, DISCHARGE, DONE. The block has one cycle counter, cleared on every state entry.
- **IDLE:** `afe_sel_o`=00, `afe_reset_o`=1. On `start_i`=1 with `abort_i`=0, go to WAIT_REF. If both are high, stay in IDLE.
- **WAIT_REF:** `afe_reset_o`=1.
  - Synchronized ref_ok=1 → AUTOZERO.
  - Counter reaches T_REF-1 with ref_ok still 0 → err=1, go to DISCHARGE.
- **AUTOZERO:** `afe_sel_o`=00, `afe_reset_o`=0, for T_AZ cycles. Then go to INTEGRATE.
- **INTEGRATE:** `afe_sel_o`=01, for T_INT cycles.
  - On the last cycle, latch sign = synchronized comp. `polarity_o` candidate = sign.
  - If sign=1, set `ref_sign_o`=1 and go to DEINT with `afe_sel_o`=11.
  - If sign=0, set `ref_sign_o`=0 and go to DEINT with `afe_sel_o`=10.
- **Saturation:** synchronized `sat_hi_i` or `sat_lo_i` in INTEGRATE or DEINT → overrange=1, result=N_MAX, go to DISCHARGE.
- **DEINT:** the counter increments each cycle starting at 0.
  - On the first cycle where synchronized comp ≠ latched sign: result = counter value, go to DISCHARGE.
  - If the counter reaches N_MAX without a crossing: result = N_MAX, overrange=1, go to DISCHARGE.
  - The 2-cycle synchronizer latency is included in the result. Firmware calibrates it out.
- **DISCHARGE:** `afe_sel_o`=00, `afe_reset_o`=1, `ref_sign_o`=0, for T_DIS cycles. Then go to DONE.
- **DONE:** one cycle.
  - `done_o`=1.
  - `result_o`, `polarity_o`, `overrange_o` and `err_o` update from internal registers in this cycle.
  - Then go to IDLE.
- **Abort:** `abort_i`=1 in WAIT_REF, AUTOZERO, INTEGRATE or DEINT → err=1, result=0, go to DISCHARGE. Abort is ignored in DISCHARGE and DONE, so the discharge always completes.
- **Priority within one cycle:** abort > saturation > crossing/limit > phase timeout.

## Timing
- **Reset values:**
  - `afe_sel_o`=00, `afe_reset_o`=1, `ref_sign_o`=0.
  - `busy_o`=0, `done_o`=0.
  - `result_o`=0, `polarity_o`=0, `overrange_o`=0, `err_o`=0.
  - Synchronizers reset to 0. State = IDLE.
- All outputs are registered and change on the clock edge following the state decision.
- Start is accepted at edge 0; `busy_o`=1 and state is WAIT_REF after edge 1.
- With ref_ok steady high, WAIT_REF lasts 1 cycle.
- Phase lengths are exactly T_AZ, T_INT and T_DIS cycles. DEINT lasts result+1 cycles.
- `done_o` asserts 1 cycle after DISCHARGE ends. `busy_o` falls together with `done_o` deasserting.
- Reset asserted mid-conversion: immediate return to reset values, including `afe_reset_o`=1. No done pulse is produced.

## Test plan
Parameters for all tests: T_REF=8, T_AZ=4, T_INT=16, N_MAX=32, T_DIS=3, CW=6.

1. **Reset mid-INTEGRATE:** assert reset → all outputs at reset values next cycle. A `start_i` during reset is ignored.
2. **Positive input:** comp_i=1 through INTEGRATE; synchronized comp falls at DEINT count 10 →
   - DEINT shows `afe_sel_o`=11, `ref_sign_o`=1.
   - DONE shows `result_o`=10, `polarity_o`=1, `overrange_o`=0, `err_o`=0.
   - `done_o` arrives exactly 1+4+16+11+3+1 cycles after start.
3. **Negative input:** comp_i=0; synchronized comp rises at count 5 → `afe_sel_o`=10, `result_o`=5, `polarity_o`=0.
4. **Overrange:**
   - comp never flips → `result_o`=32, `overrange_o`=1.
   - Separate run: `sat_hi_i` pulsed mid-INTEGRATE → DISCHARGE within 3 cycles, `overrange_o`=1.
5. **Reference timeout:** `ref_ok_i`=0 → after 8 WAIT_REF cycles, `err_o`=1 and `done_o` pulses. AFE_sel never leaves 00.
6. **Abort and start handling:**
   - `abort_i` at INTEGRATE cycle 7 → `err_o`=1, `result_o`=0, 3 discharge cycles, then `done_o`.
   - A second `start_i` while busy is ignored.
   - `start_i` and `abort_i` together in IDLE → stays IDLE.

Source files
------------

// File: rtl/dual_slope_seq_if.sv
// Signal bundle between the dual-slope sequencer and its surroundings
// (register/SPI side and analog front-end). The master drives the controls.
interface dual_slope_seq_if #(
  parameter int CW = 14
);
  logic          start_i;
  logic          abort_i;
  logic          comp_i;
  logic          sat_hi_i;
  logic          sat_lo_i;
  logic          ref_ok_i;
  logic [1:0]    afe_sel_o;
  logic          ref_sign_o;
  logic          afe_reset_o;
  logic          busy_o;
  logic          done_o;
  logic [CW-1:0] result_o;
  logic          polarity_o;
  logic          overrange_o;
  logic          err_o;

  modport master (
    output start_i, abort_i, comp_i, sat_hi_i, sat_lo_i, ref_ok_i,
    input  afe_sel_o, ref_sign_o, afe_reset_o, busy_o, done_o,
           result_o, polarity_o, overrange_o, err_o
  );

  modport slave (
    input  start_i, abort_i, comp_i, sat_hi_i, sat_lo_i, ref_ok_i,
    output afe_sel_o, ref_sign_o, afe_reset_o, busy_o, done_o,
           result_o, polarity_o, overrange_o, err_o
  );
endinterface

// File: rtl/dual_slope_seq.sv
// Dual-slope converter sequencer: reference wait, auto-zero, integrate,
// de-integrate with zero-crossing count, and integrator discharge.
module dual_slope_seq #(
  parameter int T_REF = 1024,
  parameter int T_AZ  = 256,
  parameter int T_INT = 4096,
  parameter int N_MAX = 8192,
  parameter int T_DIS = 64,
  parameter int CW    = 14
) (
  input logic              clk_i,
  input logic              rst_n_i,
  dual_slope_seq_if.slave  bus
);

  localparam int MAX_AB  = (T_REF > T_AZ) ? T_REF : T_AZ;
  localparam int MAX_CD  = (T_INT > T_DIS) ? T_INT : T_DIS;
  localparam int MAX_T   = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int MAX_V   = (MAX_T > N_MAX) ? MAX_T : N_MAX;
  localparam int CNT_NAT = $clog2(MAX_V + 1);
  localparam int CNT_W   = (CNT_NAT > CW) ? CNT_NAT : CW;

  localparam logic [CNT_W-1:0] REF_LAST  = CNT_W'(T_REF - 1);
  localparam logic [CNT_W-1:0] AZ_LAST   = CNT_W'(T_AZ - 1);
  localparam logic [CNT_W-1:0] INT_LAST  = CNT_W'(T_INT - 1);
  localparam logic [CNT_W-1:0] DIS_LAST  = CNT_W'(T_DIS - 1);
  localparam logic [CNT_W-1:0] DEINT_LIM = CNT_W'(N_MAX);
  localparam logic [CW-1:0]    RES_MAX   = CW'(N_MAX);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_REF,
    S_AUTOZERO,
    S_INTEGRATE,
    S_DEINT,
    S_DISCHARGE,
    S_DONE
  } state_t;

  state_t           state, next_state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       sync1, sync2;
  logic             comp_s, sat_s, ref_s;

  logic             sign_q, sign_d;
  logic [CW-1:0]    res_q, res_d;
  logic             ovr_q, ovr_d;
  logic             err_q, err_d;

  logic [1:0]       sel_d;
  logic             ref_sign_d, afe_reset_d;

  logic [1:0]       sel_q;
  logic             ref_sign_q, afe_reset_q, busy_q, done_q;
  logic [CW-1:0]    result_q;
  logic             polarity_q, overrange_q, err_out_q;

  // Bit order: comp, sat_hi, sat_lo, ref_ok
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {bus.comp_i, bus.sat_hi_i, bus.sat_lo_i, bus.ref_ok_i};
      sync2 <= sync1;
    end
  end

  assign comp_s = sync2[3];
  assign sat_s  = sync2[2] | sync2[1];
  assign ref_s  = sync2[0];

  always_comb begin
    next_state = state;
    sign_d     = sign_q;
    res_d      = res_q;
    ovr_d      = ovr_q;
    err_d      = err_q;

    case (state)
      S_IDLE: begin
        if (bus.start_i && !bus.abort_i) begin
          next_state = S_WAIT_REF;
          sign_d     = 1'b0;
          res_d      = '0;
          ovr_d      = 1'b0;
          err_d      = 1'b0;
        end
      end
      S_WAIT_REF: begin
        if (ref_s) begin
          next_state = S_AUTOZERO;
        end else if (cnt == REF_LAST) begin
          err_d      = 1'b1;
          next_state = S_DISCHARGE;
        end
      end
      S_AUTOZERO: begin
        if (cnt == AZ_LAST) next_state = S_INTEGRATE;
      end
      S_INTEGRATE: begin
        if (sat_s) begin
          ovr_d      = 1'b1;
          res_d      = RES_MAX;
          next_state = S_DISCHARGE;
        end else if (cnt == INT_LAST) begin
          sign_d     = comp_s;
          next_state = S_DEINT;
        end
      end
      S_DEINT: begin
        if (sat_s) begin
          ovr_d      = 1'b1;
          res_d      = RES_MAX;
          next_state = S_DISCHARGE;
        end else if (comp_s != sign_q) begin
          res_d      = cnt[CW-1:0];
          next_state = S_DISCHARGE;
        end else if (cnt == DEINT_LIM) begin
          ovr_d      = 1'b1;
          res_d      = RES_MAX;
          next_state = S_DISCHARGE;
        end
      end
      S_DISCHARGE: begin
        if (cnt == DIS_LAST) next_state = S_DONE;
      end
      S_DONE: begin
        next_state = S_IDLE;
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase

    // Abort outranks everything, but never cuts a discharge short
    if (bus.abort_i && (state == S_WAIT_REF || state == S_AUTOZERO ||
                        state == S_INTEGRATE || state == S_DEINT)) begin
      next_state = S_DISCHARGE;
      err_d      = 1'b1;
      res_d      = '0;
      ovr_d      = ovr_q;
      sign_d     = sign_q;
    end

    sel_d       = 2'b00;
    ref_sign_d  = 1'b0;
    afe_reset_d = 1'b1;
    case (next_state)
      S_AUTOZERO: begin
        afe_reset_d = 1'b0;
      end
      S_INTEGRATE: begin
        sel_d       = 2'b01;
        afe_reset_d = 1'b0;
      end
      S_DEINT: begin
        sel_d       = sign_d ? 2'b11 : 2'b10;
        ref_sign_d  = sign_d;
        afe_reset_d = 1'b0;
      end
      default: begin
        sel_d = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state  <= S_IDLE;
      cnt    <= '0;
      sign_q <= 1'b0;
      res_q  <= '0;
      ovr_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state  <= next_state;
      cnt    <= (next_state != state || state == S_IDLE) ? '0 : cnt + CNT_W'(1);
      sign_q <= sign_d;
      res_q  <= res_d;
      ovr_q  <= ovr_d;
      err_q  <= err_d;
    end
  end

  // Outputs are registered from the next-state decode so they track the state register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sel_q       <= 2'b00;
      ref_sign_q  <= 1'b0;
      afe_reset_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= '0;
      polarity_q  <= 1'b0;
      overrange_q <= 1'b0;
      err_out_q   <= 1'b0;
    end else begin
      sel_q       <= sel_d;
      ref_sign_q  <= ref_sign_d;
      afe_reset_q <= afe_reset_d;
      busy_q      <= (next_state != S_IDLE);
      done_q      <= (next_state == S_DONE);
      if (next_state == S_DONE) begin
        result_q    <= res_q;
        polarity_q  <= sign_q;
        overrange_q <= ovr_q;
        err_out_q   <= err_q;
      end
    end
  end

  assign bus.afe_sel_o   = sel_q;
  assign bus.ref_sign_o  = ref_sign_q;
  assign bus.afe_reset_o = afe_reset_q;
  assign bus.busy_o      = busy_q;
  assign bus.done_o      = done_q;
  assign bus.result_o    = result_q;
  assign bus.polarity_o  = polarity_q;
  assign bus.overrange_o = overrange_q;
  assign bus.err_o       = err_out_q;

endmodule
